// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transfer sequencer: default widths,
// FSM state encoding and the "what comes after a word" decision.
package spi_pkg;

    localparam int SPI_DATA_WIDTH = 16;
    localparam int SPI_REG_WIDTH  = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_WAIT_RESP = 3'd2,
        ST_ACK       = 3'd3,
        ST_SHIFT     = 3'd4,
        ST_STORE     = 3'd5
    } state_t;

    // Start (or continue with) a word only while running and TX has data.
    function automatic state_t fetch_or_idle(input logic enable, input logic tx_empty);
        return (enable && !tx_empty) ? ST_FETCH : ST_IDLE;
    endfunction

endpackage

// File: rtl/spi_xfer_sequencer.sv
// Sequences one SPI word at a time: pull a word from the TX FIFO, hand it
// to the shift engine, then push the received word into the RX FIFO
// (unless running TX-only). Every output comes straight from a flop.
module spi_xfer_sequencer
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_DATA_WIDTH,
    parameter int REG_WIDTH  = SPI_REG_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  soft_rst_i,
    input  logic                  enable_i,
    input  logic                  tx_only_i,
    // TX FIFO read side
    input  logic                  tx_empty_i,
    output logic                  tx_req_o,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_resp_i,
    output logic                  tx_ack_o,
    // shift engine
    output logic                  shift_start_o,
    output logic [DATA_WIDTH-1:0] shift_data_o,
    input  logic                  shift_done_i,
    input  logic [DATA_WIDTH-1:0] shift_data_i,
    // RX FIFO write side
    input  logic                  rx_full_i,
    output logic                  rx_req_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    input  logic                  rx_ack_i,
    // status
    output logic                  busy_o,
    output logic [REG_WIDTH-1:0]  xfer_count_o
);

    state_t                state_q, state_d;
    logic                  tx_req_q, tx_ack_q, shift_start_q, rx_req_q, busy_q;
    logic [DATA_WIDTH-1:0] shift_data_q, shift_data_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic [REG_WIDTH-1:0]  count_q, count_d;
    logic                  word_done;

    // Next-state, datapath capture and word-completion decode.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        shift_data_d = shift_data_q;
        rx_data_d    = rx_data_q;
        count_d      = count_q;
        word_done    = 1'b0;

        if (soft_rst_i) begin
            // Abort whatever is in flight; the word is not counted.
            state_d      = ST_IDLE;
            shift_data_d = '0;
            rx_data_d    = '0;
            count_d      = '0;
        end else begin
            case (state_q)
                ST_IDLE:      state_d = fetch_or_idle(enable_i, tx_empty_i);
                ST_FETCH:     state_d = ST_WAIT_RESP;
                ST_WAIT_RESP: begin
                    if (tx_resp_i) begin
                        shift_data_d = tx_data_i;
                        state_d      = ST_ACK;
                    end
                end
                ST_ACK:       state_d = ST_SHIFT;
                ST_SHIFT: begin
                    if (shift_done_i) begin
                        rx_data_d = shift_data_i;
                        // tx_only_i matters only at this instant.
                        if (tx_only_i) begin
                            word_done = 1'b1;
                        end else begin
                            state_d = ST_STORE;
                        end
                    end
                end
                ST_STORE: begin
                    // A full RX FIFO just stretches the request.
                    if (rx_ack_i && !rx_full_i) begin
                        word_done = 1'b1;
                    end
                end
                default:      state_d = ST_IDLE;
            endcase

            // Finishing a word goes straight to the next fetch when possible;
            // enable_i only takes effect at this word boundary.
            if (word_done) begin
                state_d = fetch_or_idle(enable_i, tx_empty_i);
                count_d = count_q + REG_WIDTH'(1);
            end
        end
    end

    // State register and the strobes decoded from the upcoming state.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q       <= ST_IDLE;
            tx_req_q      <= 1'b0;
            tx_ack_q      <= 1'b0;
            shift_start_q <= 1'b0;
            rx_req_q      <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments in clocked blocks, so every flop
            // samples the pre-edge values regardless of statement order.
            state_q       <= state_d;
            tx_req_q      <= (state_d == ST_FETCH);
            tx_ack_q      <= (state_d == ST_ACK);
            shift_start_q <= (state_d == ST_ACK);
            rx_req_q      <= (state_d == ST_STORE);
            busy_q        <= (state_d != ST_IDLE);
        end
    end

    // TX word held for the shift engine and RX word held for the FIFO.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            shift_data_q <= '0;
            rx_data_q    <= '0;
        end else begin
            shift_data_q <= shift_data_d;
            rx_data_q    <= rx_data_d;
        end
    end

    // Completed-word counter, wraps naturally at 2^REG_WIDTH.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tx_req_o      = tx_req_q;
    assign tx_ack_o      = tx_ack_q;
    assign shift_start_o = shift_start_q;
    assign shift_data_o  = shift_data_q;
    assign rx_req_o      = rx_req_q;
    assign rx_data_o     = rx_data_q;
    assign busy_o        = busy_q;
    assign xfer_count_o  = count_q;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Bench for spi_xfer_sequencer. The bench plays TX FIFO, shift engine and
// RX FIFO; the model is a TX word queue plus expected counters for words,
// FIFO pulls and RX writes. The counter is built narrow (8 bits) so its
// wrap from all-ones to zero is reachable in a short run.
module tb_spi_xfer_sequencer;

    localparam int DW   = 16;
    localparam int RW   = 8;
    localparam int MASK = (1 << RW) - 1;

    logic          clk_i = 1'b0;
    logic          arst_i, soft_rst_i, enable_i, tx_only_i;
    logic          tx_empty_i, tx_resp_i, shift_done_i, rx_full_i, rx_ack_i;
    logic [DW-1:0] tx_data_i, shift_data_i;
    logic          tx_req_o, tx_ack_o, shift_start_o, rx_req_o, busy_o;
    logic [DW-1:0] shift_data_o, rx_data_o;
    logic [RW-1:0] xfer_count_o;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [DW-1:0] tx_q[$];
    int            exp_count  = 0;
    int            exp_acks   = 0;
    int            exp_writes = 0;
    logic [DW-1:0] exp_rx     = '0;

    // observed handshake totals
    int mon_acks   = 0;
    int mon_writes = 0;

    always #5 clk_i = ~clk_i;

    spi_xfer_sequencer #(.DATA_WIDTH(DW), .REG_WIDTH(RW)) dut (
        .clk_i        (clk_i),
        .arst_i       (arst_i),
        .soft_rst_i   (soft_rst_i),
        .enable_i     (enable_i),
        .tx_only_i    (tx_only_i),
        .tx_empty_i   (tx_empty_i),
        .tx_req_o     (tx_req_o),
        .tx_data_i    (tx_data_i),
        .tx_resp_i    (tx_resp_i),
        .tx_ack_o     (tx_ack_o),
        .shift_start_o(shift_start_o),
        .shift_data_o (shift_data_o),
        .shift_done_i (shift_done_i),
        .shift_data_i (shift_data_i),
        .rx_full_i    (rx_full_i),
        .rx_req_o     (rx_req_o),
        .rx_data_o    (rx_data_o),
        .rx_ack_i     (rx_ack_i),
        .busy_o       (busy_o),
        .xfer_count_o (xfer_count_o)
    );

    // Count FIFO pulls and RX writes mid-cycle, away from the clock edge.
    always @(negedge clk_i) begin
        if (!arst_i) begin
            if (tx_ack_o) mon_acks++;
            if (rx_req_o && rx_ack_i) mon_writes++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] w);
        tx_q.push_back(w);
        tx_empty_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_strobes"}, {tx_req_o, tx_ack_o, shift_start_o, rx_req_o, busy_o}, 0);
        check({tag, "_shift_data"}, shift_data_o, 0);
        check({tag, "_rx_data"}, rx_data_o, 0);
        check({tag, "_count"}, xfer_count_o, 0);
    endtask

    // Bounded wait for the DUT to request a TX word.
    task automatic wait_fetch(input int limit);
        int n = 0;
        while (tx_req_o !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        check("fetch_seen", tx_req_o, 1);
    endtask

    // One full word starting with the DUT in FETCH. Spurious strobes are
    // injected where they must be ignored; tx_only_i carries the opposite
    // value except at the shift_done_i instant.
    task automatic do_word(input logic [DW-1:0] rx_word, input bit only, input int stall);
        logic [DW-1:0] word;
        logic          fetch_next;
        word      = tx_q[0];
        tx_only_i = ~only;
        tick();
        check("req_one_cycle", tx_req_o, 0);
        shift_done_i = 1'b1;
        shift_data_i = ~rx_word;
        tick();
        shift_done_i = 1'b0;
        check("wait_ignores_done", {tx_ack_o, shift_start_o, rx_req_o}, 0);
        check("wait_rx_hold", rx_data_o, exp_rx);
        tx_data_i = word;
        tx_resp_i = 1'b1;
        tick();
        tx_data_i = ~word;
        check("ack_and_start", {tx_ack_o, shift_start_o}, 2'b11);
        check("busy_mid_word", busy_o, 1);
        void'(tx_q.pop_front());
        tx_empty_i = (tx_q.size() == 0);
        exp_acks++;
        tick();
        check("ack_one_cycle", {tx_ack_o, shift_start_o}, 0);
        check("shift_data", shift_data_o, word);
        tick();
        tx_resp_i = 1'b0;
        check("shift_ignores_resp", shift_data_o, word);
        shift_data_i = rx_word;
        shift_done_i = 1'b1;
        tx_only_i    = only;
        tick();
        shift_done_i = 1'b0;
        tx_only_i    = ~only;
        exp_rx       = rx_word;
        check("rx_data", rx_data_o, exp_rx);
        check("shift_data_hold", shift_data_o, word);
        if (!only) begin
            check("rx_req_on", rx_req_o, 1);
            for (int i = 0; i < stall; i++) begin
                rx_full_i = 1'b1;
                tick();
                check("stall_req_no_fetch", {rx_req_o, tx_req_o}, 2'b10);
            end
            rx_full_i = 1'b0;
            rx_ack_i  = 1'b1;
            tick();
            rx_ack_i = 1'b0;
            exp_writes++;
        end
        exp_count++;
        fetch_next = enable_i && (tx_q.size() != 0);
        check("rx_req_off", rx_req_o, 0);
        check("count", xfer_count_o, exp_count & MASK);
        check("next_fetch", tx_req_o, fetch_next);
        check("busy_after_word", busy_o, fetch_next);
    endtask

    initial begin
        logic [DW-1:0] w;
        arst_i       = 1'b1;
        soft_rst_i   = 1'b0;
        enable_i     = 1'b0;
        tx_only_i    = 1'b0;
        tx_empty_i   = 1'b1;
        tx_data_i    = '0;
        tx_resp_i    = 1'b0;
        shift_done_i = 1'b0;
        shift_data_i = '0;
        rx_full_i    = 1'b0;
        rx_ack_i     = 1'b0;
        repeat (2) tick();
        check_all_zero("reset");
        arst_i = 1'b0;

        // Enabled but TX empty: stays idle.
        enable_i = 1'b1;
        repeat (3) tick();
        check("idle_when_empty", {busy_o, tx_req_o}, 0);

        // Single known word, request one cycle after TX goes non-empty.
        push(16'hA5A5);
        tick();
        check("fetch_latency", tx_req_o, 1);
        do_word(16'h3C3C, 1'b0, 0);
        check("single_acks", mon_acks, exp_acks);
        check("single_writes", mon_writes, exp_writes);

        // Three random words back to back.
        for (int i = 0; i < 3; i++) push(DW'($urandom));
        tick();
        wait_fetch(4);
        for (int i = 0; i < 3; i++) do_word(DW'($urandom), 1'b0, 0);

        // RX FIFO full for 10 cycles.
        push(DW'($urandom));
        tick();
        wait_fetch(4);
        do_word(DW'($urandom), 1'b0, 10);
        check("stall_writes", mon_writes, exp_writes);

        // TX-only word: no RX write.
        push(DW'($urandom));
        tick();
        wait_fetch(4);
        do_word(DW'($urandom), 1'b1, 0);
        check("tx_only_writes", mon_writes, exp_writes);

        // enable_i drops mid-word: word completes, then idle.
        push(DW'($urandom));
        push(DW'($urandom));
        tick();
        wait_fetch(4);
        enable_i = 1'b0;
        do_word(DW'($urandom), 1'b0, $urandom_range(0, 3));
        tx_q.delete();
        tx_empty_i = 1'b1;

        // Asynchronous reset during ACK acts before the next edge.
        enable_i = 1'b1;
        w = DW'($urandom);
        push(w);
        tick();
        wait_fetch(4);
        tick();
        tx_data_i = w;
        tx_resp_i = 1'b1;
        tick();
        tx_resp_i = 1'b0;
        check("pre_arst_ack", tx_ack_o, 1);
        #2 arst_i = 1'b1;
        #1 check_all_zero("async_reset");
        arst_i = 1'b0;
        tx_q.delete();
        tx_empty_i = 1'b1;
        exp_count  = 0;
        exp_rx     = '0;
        tick();

        // One word so the counter is non-zero before the soft reset.
        push(DW'($urandom));
        tick();
        wait_fetch(4);
        do_word(DW'($urandom), 1'b0, 0);

        // Soft reset while shifting.
        w = DW'($urandom);
        push(w);
        tick();
        wait_fetch(4);
        tick();
        tx_data_i = w;
        tx_resp_i = 1'b1;
        tick();
        tx_resp_i = 1'b0;
        void'(tx_q.pop_front());
        exp_acks++;
        tick();
        check("pre_soft_shift_data", shift_data_o, w);
        push(DW'($urandom));
        soft_rst_i = 1'b1;
        tick();
        exp_count = 0;
        exp_rx    = '0;
        check_all_zero("soft_reset");
        tick();
        check("soft_reset_held_idle", {busy_o, tx_req_o}, 0);
        enable_i     = 1'b0;
        soft_rst_i   = 1'b0;
        shift_done_i = 1'b1;
        shift_data_i = DW'($urandom);
        tick();
        shift_done_i = 1'b0;
        tick();
        check_all_zero("late_done_ignored");
        tx_q.delete();
        tx_empty_i = 1'b1;

        // Counter wrap: 2^RW TX-only words takes it from all-ones to zero.
        enable_i = 1'b1;
        for (int i = 0; i < (1 << RW); i++) push(DW'($urandom));
        tick();
        wait_fetch(4);
        for (int i = 0; i < MASK; i++) do_word(DW'($urandom), 1'b1, 0);
        check("count_all_ones", xfer_count_o, MASK);
        do_word(DW'($urandom), 1'b1, 0);
        check("count_wrapped", xfer_count_o, 0);

        tick();
        check("total_acks", mon_acks, exp_acks);
        check("total_writes", mon_writes, exp_writes);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_xfer_sequencer.md
SPI_XFER_SEQUENCER -- requirements
Module: spi_xfer_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning SPI word width.
REQ-002 SHALL have parameter REG_WIDTH, default 16, meaning transfer-counter width.
REQ-003 SHALL have port clk_i, input, 1, single clock; all logic rising-edge.
REQ-004 SHALL have port arst_i, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports soft_rst_i, input, 1 (sync active-high soft reset); enable_i, input, 1 (run transfers); tx_only_i, input, 1 (discard RX words).
REQ-006 SHALL have TX FIFO read ports: tx_empty_i in 1; tx_req_o out 1; tx_data_i in DATA_WIDTH; tx_resp_i in 1; tx_ack_o out 1.
REQ-007 SHALL have shift-engine ports: shift_start_o out 1; shift_data_o out DATA_WIDTH; shift_done_i in 1; shift_data_i in DATA_WIDTH.
REQ-008 SHALL have RX FIFO write ports: rx_full_i in 1; rx_req_o out 1; rx_data_o out DATA_WIDTH; rx_ack_i in 1.
REQ-009 SHALL have status ports busy_o out 1 (state != IDLE) and xfer_count_o out REG_WIDTH (completed words).

Function
REQ-010 SHALL implement FSM states IDLE, FETCH, WAIT_RESP, ACK, SHIFT, STORE; all outputs registered.
REQ-011 IDLE: when enable_i=1 and tx_empty_i=0, SHALL go to FETCH; otherwise stay.
REQ-012 FETCH: SHALL assert tx_req_o for exactly one cycle, then go to WAIT_RESP.
REQ-013 WAIT_RESP: on tx_resp_i=1 SHALL latch tx_data_i into shift_data_o, go to ACK.
REQ-014 ACK: SHALL assert tx_ack_o for exactly one cycle (one FIFO pull per word) and shift_start_o for exactly one cycle simultaneously, then go to SHIFT.
REQ-015 SHIFT: SHALL hold shift_data_o stable; on shift_done_i=1 latch shift_data_i into rx_data_o; go to STORE if tx_only_i=0, else complete the word.
REQ-016 STORE: SHALL hold rx_req_o=1 until rx_ack_i=1, deassert on the cycle after rx_ack_i (never two writes per word); rx_full_i=1 only stalls, no drop.
REQ-017 Word completion SHALL increment xfer_count_o by 1, modulo 2^REG_WIDTH (0xFFFF -> 0x0000 wrap at default).
REQ-018 After completion SHALL go to FETCH if enable_i=1 and tx_empty_i=0, else IDLE (back-to-back words, no IDLE cycle).
REQ-019 enable_i falling mid-word SHALL NOT abort; current word finishes, then IDLE.
REQ-020 tx_only_i SHALL be sampled at shift_done_i; changes elsewhere have no effect on the in-flight word.
REQ-021 shift_done_i or tx_resp_i outside SHIFT/WAIT_RESP SHALL be ignored.
REQ-022 Latency: enable_i rising with TX non-empty -> tx_req_o at cycle +1; tx_resp_i -> shift_start_o at +1.

Reset
REQ-023 arst_i=1 SHALL force immediately: state IDLE, tx_req_o=0, tx_ack_o=0, shift_start_o=0, rx_req_o=0, busy_o=0, shift_data_o=0, rx_data_o=0, xfer_count_o=0.
REQ-024 soft_rst_i=1 SHALL apply the same values at next edge from any state, including mid-SHIFT/STORE; FSM SHALL stay IDLE while soft_rst_i=1.
REQ-025 A word aborted by soft reset SHALL NOT increment xfer_count_o nor issue tx_ack_o/rx_req_o.

Structure
REQ-026 State encodings and default DATA_WIDTH/REG_WIDTH SHALL live in shared package spi_pkg.
REQ-027 No sub-module SHALL be required; counter and FSM inline, one always block per registered group.

Verification
REQ-028 TX holds 0xA5A5, enable_i=1 -> one tx_req_o, one tx_ack_o, shift_data_o=0xA5A5, shift_done_i with 0x3C3C -> rx_data_o=0x3C3C written once, xfer_count_o=1.
REQ-029 TX holds 3 words, enable_i held -> 3 back-to-back words without IDLE, xfer_count_o=3, busy_o low after third.
REQ-030 rx_full_i=1, rx_ack_i withheld 10 cycles -> rx_req_o held 10 cycles, no FETCH, single write on release.
REQ-031 tx_only_i=1, one word -> rx_req_o never asserted, xfer_count_o=1.
REQ-032 soft_rst_i pulsed during SHIFT -> all outputs 0 next cycle, xfer_count_o=0, later shift_done_i ignored.
REQ-033 Preload xfer_count_o=0xFFFF via 65535 words (or force) then one word -> 0x0000.
